// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: mul/div FSM states,
// forwarding-select encodings and the load-use hazard predicate.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } md_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,  // operand from the register file
        FWD_WB  = 2'b01,  // operand bypassed from writeback
        FWD_MEM = 2'b10   // operand bypassed from memory
    } fwd_sel_e;

    // A load in execute whose destination feeds either decode-stage source.
    function automatic logic is_load_use(
        input logic                  mem_read,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2
    );
        return mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_sel.sv
// Operand forwarding select for one execute-stage source register.
// The memory stage is younger than writeback, so it takes priority.
module forward_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rd_m_i,
    input  logic [REG_ADDR_W-1:0] rd_w_i,
    input  logic                  reg_write_m_i,
    input  logic                  reg_write_w_i,
    output logic [1:0]            fwd_o
);

    fwd_sel_e sel;

    // Priority mux: memory hit, then writeback hit, else register file.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            sel = FWD_MEM;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            sel = FWD_WB;
        end
    end

    assign fwd_o = sel;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch
// flush, and a mul/div launch FSM (IDLE/BUSY/DRAIN) with a watchdog.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush
// performance counters (stall_cnt, flush_cnt).
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 64,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rs1_E,
    input  logic [REG_ADDR_W-1:0] rs2_E,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_W,
    input  logic                  MemRead_E,
    input  logic                  RegWrite_M,
    input  logic                  RegWrite_W,
    input  logic                  PCSrc_E,
    input  logic                  MulDiv_E,
    input  logic                  md_done,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardA_E,
    output logic [1:0]            ForwardB_E,
    output logic                  md_start,
    output logic                  md_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int             WD_W     = (MD_MAX_CYCLES > 1) ? $clog2(MD_MAX_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MD_MAX_CYCLES - 1);

    // CNT_W only sizes the perf counters; a non-positive width yields this
    // empty marker block so the mistake is visible in the elaborated hierarchy.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    md_state_e       state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            load_use;

    assign load_use = is_load_use(MemRead_E, rd_E, rs1_D, rs2_D);

    forward_sel u_fwd_a (
        .rs_i          (rs1_E),
        .rd_m_i        (rd_M),
        .rd_w_i        (rd_W),
        .reg_write_m_i (RegWrite_M),
        .reg_write_w_i (RegWrite_W),
        .fwd_o         (ForwardA_E)
    );

    forward_sel u_fwd_b (
        .rs_i          (rs2_E),
        .rd_m_i        (rd_M),
        .rd_w_i        (rd_W),
        .reg_write_m_i (RegWrite_M),
        .reg_write_w_i (RegWrite_W),
        .fwd_o         (ForwardB_E)
    );

    // Next-state, watchdog and hazard outputs; all control outputs forced low while in reset.
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        md_start   = 1'b0;
        md_timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A resolved branch discards the younger instructions, so
                // stalling them for a load-use would be pointless.
                if (PCSrc_E) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
                if (MulDiv_E && !PCSrc_E) begin
                    md_start = 1'b1;
                    wd_d     = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                // A result on the limit cycle is still a valid completion.
                if (md_done) begin
                    state_d = DRAIN;
                end else if (wd_q == WD_LIMIT) begin
                    md_timeout = 1'b1;
                    state_d    = DRAIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DRAIN: begin
                // One free cycle lets the mul/div instruction leave execute,
                // so it cannot be launched a second time.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!reset_n) begin
            StallF     = 1'b0;
            StallD     = 1'b0;
            StallE     = 1'b0;
            FlushD     = 1'b0;
            FlushE     = 1'b0;
            md_start   = 1'b0;
            md_timeout = 1'b0;
        end
    end

    // FSM state and watchdog registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating counts of fetch-stall and execute-flush cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (FlushE && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share inputs:
// dut0 with the default watchdog limit, dut1 with MD_MAX_CYCLES=8.
// Directed scenarios first, then randomized cycles, all against a cycle
// model of the hazard rules. Counter checks build when HAZARD_PERF_EN is set.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E, MulDiv_E, md_done;

    logic       stall_f[2], stall_d[2], stall_e[2], flush_d[2], flush_e[2];
    logic       mds[2], mdt[2];
    logic [1:0] fwd_a[2], fwd_b[2];
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt[2], flush_cnt[2];
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut0 (
        .clk(clk), .reset_n(reset_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .MemRead_E(MemRead_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E), .md_done(md_done),
        .StallF(stall_f[0]), .StallD(stall_d[0]), .StallE(stall_e[0]),
        .FlushD(flush_d[0]), .FlushE(flush_e[0]),
        .ForwardA_E(fwd_a[0]), .ForwardB_E(fwd_b[0]),
        .md_start(mds[0]), .md_timeout(mdt[0])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
`endif
    );

    pipeline_hazard_ctrl #(.MD_MAX_CYCLES(8)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .MemRead_E(MemRead_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .PCSrc_E(PCSrc_E), .MulDiv_E(MulDiv_E), .md_done(md_done),
        .StallF(stall_f[1]), .StallD(stall_d[1]), .StallE(stall_e[1]),
        .FlushD(flush_d[1]), .FlushE(flush_e[1]),
        .ForwardA_E(fwd_a[1]), .ForwardB_E(fwd_b[1]),
        .md_start(mds[1]), .md_timeout(mdt[1])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
`endif
    );

    // Reference model: a mul/div op is either in flight (with its age in
    // cycles), draining for one cycle, or absent.
    int  lim[2] = '{64, 8};
    bit  m_busy[2], m_drain[2];
    int  m_age[2];
    longint m_scnt[2], m_fcnt[2];

    // Observed tallies for the directed scenarios.
    int  t_start[2], t_se[2], t_to[2];

    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (RegWrite_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (RegWrite_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic clear_tallies();
        for (int k = 0; k < 2; k++) begin
            t_start[k] = 0; t_se[k] = 0; t_to[k] = 0;
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bit lu, sf, sd, se, fd, fe, ms, mt;
            if (!reset_n) begin
                m_busy[k] = 0; m_drain[k] = 0; m_age[k] = 0;
                m_scnt[k] = 0; m_fcnt[k] = 0;
            end
            lu = MemRead_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D);
            {sf, sd, se, fd, fe, ms, mt} = '0;
            if (reset_n) begin
                if (m_busy[k]) begin
                    sf = 1; sd = 1; se = 1;
                    mt = !md_done && (m_age[k] == lim[k] - 1);
                end else if (!m_drain[k]) begin
                    if (PCSrc_E) begin
                        fd = 1; fe = 1;
                    end else if (lu) begin
                        sf = 1; sd = 1; fe = 1;
                    end
                    ms = MulDiv_E && !PCSrc_E;
                end
            end
            check("StallF", k, stall_f[k], sf);
            check("StallD", k, stall_d[k], sd);
            check("StallE", k, stall_e[k], se);
            check("FlushD", k, flush_d[k], fd);
            check("FlushE", k, flush_e[k], fe);
            check("md_start", k, mds[k], ms);
            check("md_timeout", k, mdt[k], mt);
            check("ForwardA_E", k, fwd_a[k], fwd_ref(rs1_E));
            check("ForwardB_E", k, fwd_b[k], fwd_ref(rs2_E));
`ifdef HAZARD_PERF_EN
            check("stall_cnt", k, stall_cnt[k], m_scnt[k][31:0]);
            check("flush_cnt", k, flush_cnt[k], m_fcnt[k][31:0]);
            if (reset_n) begin
                if (sf && m_scnt[k] < 64'hFFFF_FFFF) m_scnt[k]++;
                if (fe && m_fcnt[k] < 64'hFFFF_FFFF) m_fcnt[k]++;
            end
`endif
            t_start[k] += int'(mds[k]);
            t_se[k]    += int'(stall_e[k]);
            t_to[k]    += int'(mdt[k]);
        end
        @(posedge clk);
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                if (m_busy[k]) begin
                    if (md_done || m_age[k] == lim[k] - 1) begin
                        m_busy[k] = 0; m_drain[k] = 1;
                    end else begin
                        m_age[k]++;
                    end
                end else if (m_drain[k]) begin
                    m_drain[k] = 0;
                end else if (MulDiv_E && !PCSrc_E) begin
                    m_busy[k] = 1; m_age[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        {rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W} = '0;
        {MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E, MulDiv_E, md_done} = '0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_drain[k] = 0; m_age[k] = 0; m_scnt[k] = 0; m_fcnt[k] = 0;
        end
        clear_tallies();

        // Reset with a load-use hazard present: outputs must still be low.
        reset_n = 1'b0;
        idle_inputs();
        MemRead_E = 1; rd_E = 5; rs1_D = 5;
        step();
        reset_n = 1'b1;

        // Load-use stall, then the same with rd_E = x0.
        step();
        rd_E = 0;
        step();

        // Branch together with the load-use hazard: flush wins.
        rd_E = 5; PCSrc_E = 1;
        step();
        idle_inputs();

        // Forwarding priority, then writeback-only, then operand B.
        RegWrite_M = 1; RegWrite_W = 1; rd_M = 7; rd_W = 7; rs1_E = 7;
        step();
        RegWrite_M = 0;
        step();
        rs2_E = 7; rs1_E = 3; rd_M = 3; RegWrite_M = 1;
        step();
        idle_inputs();

        // Mul/div completing in its 10th busy cycle.
        clear_tallies();
        MulDiv_E = 1;
        step();
        for (int i = 0; i < 9; i++) step();
        md_done = 1;
        step();
        MulDiv_E = 0; md_done = 0;
        step();
        step();
        check("md_start_pulses", 0, t_start[0], 1);
        check("busy_stall_cycles", 0, t_se[0], 10);
        check("no_timeout", 0, t_to[0], 0);
        for (int i = 0; i < 20; i++) step();

        // Watchdog: dut1 (limit 8) times out, dut0 keeps waiting.
        clear_tallies();
        MulDiv_E = 1;
        step();
        MulDiv_E = 0;
        for (int i = 0; i < 10; i++) step();
        check("timeout_pulses", 1, t_to[1], 1);
        check("busy_before_timeout", 1, t_se[1], 8);
        check("no_timeout_long_limit", 0, t_to[0], 0);
        md_done = 1;
        step();
        md_done = 0;
        step();
        step();

        // Reset pulse in the 4th busy cycle abandons the operation.
        clear_tallies();
        MulDiv_E = 1;
        step();
        MulDiv_E = 0;
        for (int i = 0; i < 3; i++) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("no_timeout_after_reset", 0, t_to[0], 0);
        check("no_timeout_after_reset", 1, t_to[1], 0);
        check("busy_cycles_before_reset", 1, t_se[1], 3);

        // Randomized traffic with small register numbers to force hits.
        for (int i = 0; i < 400; i++) begin
            rs1_D = 5'($urandom_range(0, 7)); rs2_D = 5'($urandom_range(0, 7));
            rs1_E = 5'($urandom_range(0, 7)); rs2_E = 5'($urandom_range(0, 7));
            rd_E  = 5'($urandom_range(0, 7)); rd_M  = 5'($urandom_range(0, 7));
            rd_W  = 5'($urandom_range(0, 7));
            MemRead_E  = ($urandom_range(0, 2) == 0);
            RegWrite_M = ($urandom_range(0, 1) == 0);
            RegWrite_W = ($urandom_range(0, 1) == 0);
            PCSrc_E    = ($urandom_range(0, 7) == 0);
            MulDiv_E   = ($urandom_range(0, 5) == 0);
            md_done    = ($urandom_range(0, 11) == 0);
            reset_n    = ($urandom_range(0, 99) != 0);
            step();
        end
        reset_n = 1'b1;
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Both SHALL be named as the codebase names them, with reset written `reset_n` to show its polarity.
REQ-002 Parameter MD_MAX_CYCLES SHALL have default 64 and is the multiply/divide watchdog limit in cycles.
REQ-003 Parameter CNT_W SHALL have default 32 and is the width of the performance counters.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- rs1_D, rs2_D  in  5  decode-stage source registers
- rs1_E, rs2_E  in  5  execute-stage source registers
- rd_E, rd_M, rd_W  in  5  destination registers per stage
- MemRead_E  in  1  load in execute
- RegWrite_M, RegWrite_W  in  1  writeback enables
- PCSrc_E  in  1  taken branch or jump resolved in execute
- MulDiv_E  in  1  multi-cycle operation in execute
- md_done  in  1  mul/div unit result valid, one-cycle pulse
- StallF, StallD, StallE  out  1  hold the fetch, decode and execute stages
- FlushD, FlushE  out  1  bubble into the IF/ID and ID/EX registers
- ForwardA_E, ForwardB_E  out  2  operand select: 00 register file, 01 writeback, 10 memory
- md_start  out  1  one-cycle launch pulse to the mul/div unit
- md_timeout  out  1  one-cycle watchdog pulse

Function
REQ-005 Forwarding SHALL be combinational. ForwardA_E SHALL be 10 when RegWrite_M && rd_M!=0 && rd_M==rs1_E. Otherwise it SHALL be 01 when RegWrite_W && rd_W!=0 && rd_W==rs1_E. Otherwise it SHALL be 00. ForwardB_E SHALL follow the same rule using rs2_E.
REQ-006 A load-use hazard SHALL be the condition MemRead_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D).
REQ-007 On a load-use hazard the block SHALL assert StallF=StallD=FlushE=1 for exactly that cycle.
REQ-008 When PCSrc_E=1 in state IDLE, the block SHALL assert FlushD=FlushE=1.
REQ-009 If PCSrc_E=1 and a load-use hazard occur in the same cycle, the flush SHALL win: StallF=StallD=0 and FlushD=FlushE=1.
REQ-010 The FSM SHALL have three states: IDLE, BUSY and DRAIN.
REQ-011 In IDLE, MulDiv_E=1 && PCSrc_E=0 SHALL produce md_start=1 for one cycle and move the FSM to BUSY on the next edge.
REQ-012 In BUSY, the block SHALL assert StallF=StallD=StallE=1 and hold FlushD=FlushE=0. PCSrc_E and load-use SHALL be ignored in BUSY.
REQ-013 In BUSY, md_done=1 SHALL move the FSM to DRAIN.
REQ-014 In DRAIN, all stalls SHALL be deasserted for one cycle and the FSM SHALL return to IDLE. md_start SHALL NOT re-fire for the same instruction.
REQ-015 A watchdog counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-016 When the watchdog reaches MD_MAX_CYCLES-1 without md_done, the block SHALL pulse md_timeout and go to DRAIN.
REQ-017 If md_done and the watchdog limit occur in the same cycle, md_done SHALL win and md_timeout SHALL stay 0.
REQ-018 md_done received in IDLE or DRAIN SHALL be ignored.

Reset
REQ-019 When reset_n=0, the FSM SHALL go to IDLE, the watchdog and performance counters SHALL clear, and md_start, md_timeout, all Stall* and all Flush* outputs SHALL be 0.
REQ-020 A reset asserted in BUSY SHALL abandon the operation and SHALL NOT pulse md_timeout.
REQ-021 After reset is released, the first edge SHALL evaluate the inputs normally.

Configuration
REQ-022 With HAZARD_PERF_EN defined, the block SHALL add outputs stall_cnt and flush_cnt, each CNT_W wide.
- stall_cnt SHALL increment on every cycle with StallF=1.
- flush_cnt SHALL increment on every cycle with FlushE=1.
- Both counters SHALL saturate at all-ones.
REQ-023 Without HAZARD_PERF_EN, these outputs and their logic SHALL be absent.

Structure
REQ-024 The FSM state enum (IDLE=0, BUSY=1, DRAIN=2) and the forwarding-select encodings SHALL live in the shared package pipe_ctrl_pkg.
REQ-025 Forwarding SHALL be implemented in the sub-module forward_sel, instantiated once per operand. Stall, flush and FSM logic SHALL stay in the top module.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Load rd_E=5, rs1_D=5, MemRead_E=1 -> StallF=StallD=FlushE=1 for one cycle. With rd_E=0, no stall.
- PCSrc_E=1 together with the same load-use hazard -> FlushD=FlushE=1 and StallF=0.
- RegWrite_M=RegWrite_W=1, rd_M=rd_W=rs1_E=7 -> ForwardA_E=10. With RegWrite_M=0 -> ForwardA_E=01.
- MulDiv_E=1, then md_done after 10 cycles -> md_start pulses once, StallE high for 10 cycles, one DRAIN cycle, then IDLE.
- MD_MAX_CYCLES=8 with md_done never asserted -> md_timeout pulses in the 8th BUSY cycle, FSM goes DRAIN then IDLE.
- reset_n pulsed low for one cycle in the 4th BUSY cycle -> outputs 0 immediately, FSM returns to IDLE, no md_timeout.
